// File: rtl/ex_hazard_ctrl_if.sv
// ex_hazard_ctrl_if: pipeline-side hazard signals; master = pipeline, slave = hazard unit
interface ex_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic ex_mem_read, mem_reg_write, wb_reg_write, ex_branch_taken;
  logic [1:0] ForwardA, ForwardB;
  logic pc_write, ifid_write, idex_bubble, ifid_flush;
  logic [CNT_W-1:0] stall_count, flush_count;
  modport master (
    output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read, mem_rd, mem_reg_write,
           wb_rd, wb_reg_write, ex_branch_taken,
    input  ForwardA, ForwardB, pc_write, ifid_write, idex_bubble, ifid_flush,
           stall_count, flush_count
  );
  modport slave (
    input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read, mem_rd, mem_reg_write,
           wb_rd, wb_reg_write, ex_branch_taken,
    output ForwardA, ForwardB, pc_write, ifid_write, idex_bubble, ifid_flush,
           stall_count, flush_count
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: EX forwarding selects, load-use stall, taken-branch squash sequencer, saturating perf counters
module ex_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  ex_hazard_ctrl_if.slave h
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic lu, br, stall, flushing;
  function automatic logic [1:0] fwd(input logic [4:0] rs, input logic mw, input logic [4:0] md,
                                     input logic ww, input logic [4:0] wd);
    return (mw && md != 5'd0 && md == rs) ? 2'b10 : (ww && wd != 5'd0 && wd == rs) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    lu = h.ex_mem_read && h.ex_rd != 5'd0 && (h.ex_rd == h.id_rs1 || h.ex_rd == h.id_rs2);
    br = state_q == RUN && h.ex_branch_taken;
    stall = state_q == RUN && !br && lu;
    flushing = br || state_q == FLUSH;
    h.ForwardA = reset ? 2'b00 : fwd(h.ex_rs1, h.mem_reg_write, h.mem_rd, h.wb_reg_write, h.wb_rd);
    h.ForwardB = reset ? 2'b00 : fwd(h.ex_rs2, h.mem_reg_write, h.mem_rd, h.wb_reg_write, h.wb_rd);
    h.pc_write = !reset && !stall;
    h.ifid_write = !reset && !stall;
    h.idex_bubble = reset || stall || flushing;
    h.ifid_flush = reset || flushing;
    h.stall_count = stall_q;
    h.flush_count = flush_q;
    state_d = state_q == FLUSH ? (fcnt_q == 2'd1 ? RUN : FLUSH) : ((br && FLUSH_CYCLES > 1) ? FLUSH : RUN);
    fcnt_d = state_q == FLUSH ? fcnt_q - 2'd1 : ((br && FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 1) : 2'd0);
    stall_d = (stall && ~&stall_q) ? stall_q + 1'b1 : stall_q;
    flush_d = (br && ~&flush_q) ? flush_q + 1'b1 : flush_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      fcnt_q <= 2'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q <= fcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: table-driven check of forwarding, stalls, squash and counters, plus reset-in-flush sequence
module tb_ex_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  ex_hazard_ctrl_if #(.CNT_W(16)) a();
  ex_hazard_ctrl_if #(.CNT_W(2)) b();
  ex_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .h(a.slave));
  ex_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) dut_b (.clk(clk), .reset(reset), .h(b.slave));
  assign b.id_rs1 = a.id_rs1;
  assign b.id_rs2 = a.id_rs2;
  assign b.ex_rs1 = a.ex_rs1;
  assign b.ex_rs2 = a.ex_rs2;
  assign b.ex_rd = a.ex_rd;
  assign b.ex_mem_read = a.ex_mem_read;
  assign b.mem_rd = a.mem_rd;
  assign b.mem_reg_write = a.mem_reg_write;
  assign b.wb_rd = a.wb_rd;
  assign b.wb_reg_write = a.wb_reg_write;
  assign b.ex_branch_taken = a.ex_branch_taken;
  typedef struct {
    logic [4:0] id1, id2, xr1, xr2, xrd;
    logic mr;
    logic [4:0] mrd;
    logic mrw;
    logic [4:0] wrd;
    logic wrw, br;
    logic [7:0] ctl;
    int sc, fc;
  } vec_t;
  localparam logic [7:0] NRM = 8'b0000_1100;
  localparam logic [7:0] STL = 8'b0000_0010;
  localparam logic [7:0] FLS = 8'b0000_1111;
  localparam logic [7:0] RST = 8'b0000_0011;
  vec_t vt[16];
  function automatic logic [7:0] ctl_of(input logic [1:0] fa, input logic [1:0] fb,
                                        input logic p, input logic i, input logic bb, input logic f);
    return {fa, fb, p, i, bb, f};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input vec_t v);
    a.id_rs1 = v.id1;
    a.id_rs2 = v.id2;
    a.ex_rs1 = v.xr1;
    a.ex_rs2 = v.xr2;
    a.ex_rd = v.xrd;
    a.ex_mem_read = v.mr;
    a.mem_rd = v.mrd;
    a.mem_reg_write = v.mrw;
    a.wb_rd = v.wrd;
    a.wb_reg_write = v.wrw;
    a.ex_branch_taken = v.br;
  endtask
  function automatic int sat2(input int x);
    return x > 3 ? 3 : x;
  endfunction
  initial begin
    vec_t z;
    vt[0]  = '{0,0,5,0,0,0,5,1,5,1,0, 8'b1000_1100, 0,0};
    vt[1]  = '{0,0,5,5,0,0,5,0,5,1,0, 8'b0101_1100, 0,0};
    vt[2]  = '{0,0,4,3,0,0,3,1,3,1,0, 8'b0010_1100, 0,0};
    vt[3]  = '{0,0,0,0,0,1,0,1,0,1,0, NRM, 0,0};
    vt[4]  = '{1,7,0,0,7,1,0,0,0,0,0, STL, 1,0};
    vt[5]  = '{1,7,0,0,7,0,0,0,0,0,0, NRM, 1,0};
    vt[6]  = '{9,0,0,0,9,1,0,0,0,0,0, STL, 2,0};
    vt[7]  = '{9,0,0,0,9,1,0,0,0,0,1, FLS, 2,1};
    vt[8]  = '{9,0,0,0,9,1,0,0,0,0,1, FLS, 2,1};
    vt[9]  = '{0,0,0,0,0,0,0,0,0,0,0, NRM, 2,1};
    vt[10] = '{0,0,0,0,0,0,0,0,0,0,1, FLS, 2,2};
    vt[11] = '{0,0,0,0,0,0,0,0,0,0,0, FLS, 2,2};
    vt[12] = '{2,0,0,0,2,1,0,0,0,0,0, STL, 3,2};
    vt[13] = '{2,0,0,0,2,1,0,0,0,0,0, STL, 4,2};
    vt[14] = '{0,2,0,0,2,1,0,0,0,0,0, STL, 5,2};
    vt[15] = '{0,0,0,0,0,0,0,0,0,0,0, NRM, 5,2};
    z = vt[15];
    drive(z);
    a.mem_rd = 5'd5;
    a.mem_reg_write = 1'b1;
    a.ex_rs1 = 5'd5;
    #3;
    chk("reset_ctl", 32'(ctl_of(a.ForwardA, a.ForwardB, a.pc_write, a.ifid_write, a.idex_bubble, a.ifid_flush)), 32'(RST));
    chk("reset_cnt", {a.stall_count, a.flush_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      chk($sformatf("v%0d_ctl", i),
          32'(ctl_of(a.ForwardA, a.ForwardB, a.pc_write, a.ifid_write, a.idex_bubble, a.ifid_flush)), 32'(vt[i].ctl));
      chk($sformatf("v%0d_bctl", i),
          32'(ctl_of(b.ForwardA, b.ForwardB, b.pc_write, b.ifid_write, b.idex_bubble, b.ifid_flush)), 32'(vt[i].ctl));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_cnt", i), {a.stall_count, a.flush_count}, {16'(vt[i].sc), 16'(vt[i].fc)});
      chk($sformatf("v%0d_bcnt", i), {28'd0, b.stall_count, b.flush_count}, {28'd0, 2'(sat2(vt[i].sc)), 2'(sat2(vt[i].fc))});
    end
    @(negedge clk);
    drive(z);
    a.ex_branch_taken = 1'b1;
    @(posedge clk);
    #1;
    chk("br3_flush_cnt", 32'(a.flush_count), 32'd3);
    chk("br3_bflush_sat", 32'(b.flush_count), 32'd3);
    @(negedge clk);
    drive(z);
    a.mem_rd = 5'd5;
    a.mem_reg_write = 1'b1;
    a.ex_rs1 = 5'd5;
    #1;
    chk("inflush_ctl", 32'(ctl_of(a.ForwardA, a.ForwardB, a.pc_write, a.ifid_write, a.idex_bubble, a.ifid_flush)), 32'h8F);
    #1;
    reset = 1'b1;
    #1;
    chk("midreset_ctl", 32'(ctl_of(a.ForwardA, a.ForwardB, a.pc_write, a.ifid_write, a.idex_bubble, a.ifid_flush)), 32'(RST));
    chk("midreset_cnt", {a.stall_count, a.flush_count}, 32'd0);
    chk("midreset_bcnt", 32'({b.stall_count, b.flush_count}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_run", 32'(ctl_of(a.ForwardA, a.ForwardB, a.pc_write, a.ifid_write, a.idex_bubble, a.ifid_flush)), 32'h8C);
    @(posedge clk);
    #1;
    chk("post_reset_cnt", {a.stall_count, a.flush_count}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
